// File: rtl/div_ratio_ctrl.sv
// Programmable clock divider: div_out has a period of active_ratio clk cycles.
// Ratio changes and stop requests take effect only at period boundaries, so div_out never produces a runt pulse.
module div_ratio_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RST_RATIO = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             period_tick,
  output logic [CNT_W-1:0] active_ratio,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [CNT_W-1:0] RST_R   = CNT_W'(RST_RATIO);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_R   = CNT_W'(2);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ratio_q;
  logic [CNT_W-1:0] pend_ratio;
  logic             err_q;

  logic             running;
  logic             boundary;
  logic             hs;
  logic             hs_bad;
  logic             hs_ok;
  logic [CNT_W-1:0] high_len;

  assign running  = (state == ST_RUN) || (state == ST_PEND);
  assign boundary = running && (cnt == ratio_q - CNT_ONE);
  assign hs       = cfg_valid && cfg_ready;
  assign hs_bad   = hs && (cfg_ratio < MIN_R);
  assign hs_ok    = hs && !hs_bad;

  // ceil(N/2) without widening: N - floor(N/2)
  assign high_len = ratio_q - (ratio_q >> 1);

  assign cfg_ready    = (state != ST_PEND);
  assign cfg_err      = err_q;
  assign div_out      = running && (cnt < high_len);
  assign period_tick  = running && (cnt == '0);
  assign active_ratio = ratio_q;
  assign busy         = (state == ST_PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ratio_q    <= RST_R;
      pend_ratio <= RST_R;
      err_q      <= 1'b0;
    end else begin
      err_q <= hs_bad;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (hs_ok) ratio_q <= cfg_ratio;
          if (en) state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= boundary ? '0 : cnt + CNT_ONE;
          // Stopping on the same boundary as a request: no period follows, so apply the ratio directly.
          if (boundary && !en) begin
            state <= ST_IDLE;
            if (hs_ok) ratio_q <= cfg_ratio;
          end else if (hs_ok) begin
            pend_ratio <= cfg_ratio;
            state      <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (boundary) begin
            cnt     <= '0;
            ratio_q <= pend_ratio;
            state   <= en ? ST_RUN : ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Scoreboard bench for div_ratio_ctrl: each driven cycle queues the expected outputs,
// which are popped and compared one time unit after the following rising edge.
module tb_div_ratio_ctrl;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic             d;
    logic             t;
    logic             rdy;
    logic             er;
    logic             bsy;
    logic [CNT_W-1:0] rat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_ratio;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_out;
  logic             period_tick;
  logic [CNT_W-1:0] active_ratio;
  logic             busy;

  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  always #5 clk = ~clk;

  div_ratio_ctrl #(.CNT_W(CNT_W), .RST_RATIO(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ratio    (cfg_ratio),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .div_out      (div_out),
    .period_tick  (period_tick),
    .active_ratio (active_ratio),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s/%s: observed %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  // Drive inputs for the next edge, queue the outputs expected after it, then compare.
  task automatic cyc(input logic e, input logic v, input logic [CNT_W-1:0] r,
                     input logic d, input logic t, input logic rdy, input logic er,
                     input logic bsy, input logic [CNT_W-1:0] rat);
    exp_t x;
    en        = e;
    cfg_valid = v;
    cfg_ratio = r;
    sb.push_back(exp_t'{d, t, rdy, er, bsy, rat});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("div_out", div_out, x.d);
      check("period_tick", period_tick, x.t);
      check("cfg_ready", cfg_ready, x.rdy);
      check("cfg_err", cfg_err, x.er);
      check("busy", busy, x.bsy);
      check("active_ratio", active_ratio, x.rat);
    end
  endtask

  // Running cycle: position idx within a period of n cycles, pend selects PEND vs RUN.
  task automatic run_cyc(input logic e, input logic v, input logic [CNT_W-1:0] r,
                         input int n, input int idx, input logic pend, input logic er,
                         input logic [CNT_W-1:0] rat);
    cyc(e, v, r, idx < (n + 1) / 2, idx == 0, !pend, er, pend, rat);
  endtask

  task automatic idle_cyc(input logic e, input logic v, input logic [CNT_W-1:0] r,
                          input logic er, input logic [CNT_W-1:0] rat);
    cyc(e, v, r, 1'b0, 1'b0, 1'b1, er, 1'b0, rat);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0;

    phase = "reset";
    idle_cyc(0, 0, 0, 0, 3);
    idle_cyc(1, 1, 9, 0, 3);       // rst beats en and a legal handshake
    rst = 1'b0;
    idle_cyc(0, 0, 0, 0, 3);

    phase = "run_n3";
    for (int i = 0; i < 12; i++) run_cyc(1, 0, 0, 3, i % 3, 0, 0, 3);

    phase = "bad_cfg_run";
    for (int i = 0; i < 6; i++)
      run_cyc(1, (i == 1) || (i == 3), (i == 1) ? 8'd1 : 8'd0, 3, i % 3, 0, (i == 1) || (i == 3), 3);

    phase = "ratio_5";
    run_cyc(1, 0, 0, 3, 0, 0, 0, 3);
    run_cyc(1, 0, 0, 3, 1, 0, 0, 3);
    run_cyc(1, 1, 5, 3, 2, 1, 0, 3);   // handshake at cnt==1
    run_cyc(1, 1, 7, 5, 0, 0, 0, 5);   // request while PEND is ignored
    for (int i = 1; i < 5; i++) run_cyc(1, 0, 0, 5, i, 0, 0, 5);

    phase = "boundary_cfg";
    run_cyc(1, 1, 3, 5, 0, 1, 0, 5);
    for (int i = 1; i < 5; i++) run_cyc(1, 0, 0, 5, i, 1, 0, 5);
    for (int i = 0; i < 3; i++) run_cyc(1, 0, 0, 3, i, 0, 0, 3);
    run_cyc(1, 1, 4, 3, 0, 1, 0, 3);   // handshake on the N=3 boundary
    run_cyc(1, 0, 0, 3, 1, 1, 0, 3);
    run_cyc(1, 0, 0, 3, 2, 1, 0, 3);
    for (int i = 0; i < 8; i++) run_cyc(1, 0, 0, 4, i % 4, 0, 0, 4);

    phase = "en_blip";
    run_cyc(1, 0, 0, 4, 0, 0, 0, 4);
    run_cyc(0, 0, 0, 4, 1, 0, 0, 4);
    run_cyc(0, 0, 0, 4, 2, 0, 0, 4);
    run_cyc(1, 0, 0, 4, 3, 0, 0, 4);
    run_cyc(1, 0, 0, 4, 0, 0, 0, 4);

    phase = "stop_n4";
    run_cyc(1, 0, 0, 4, 1, 0, 0, 4);
    run_cyc(0, 0, 0, 4, 2, 0, 0, 4);   // en sampled 0 at cnt==1
    run_cyc(0, 0, 0, 4, 3, 0, 0, 4);
    for (int i = 0; i < 5; i++) idle_cyc(0, 0, 0, 0, 4);

    phase = "bad_cfg_idle";
    idle_cyc(0, 1, 1, 1, 4);
    idle_cyc(0, 0, 0, 0, 4);
    idle_cyc(0, 1, 0, 1, 4);
    idle_cyc(0, 1, 5, 0, 5);
    idle_cyc(0, 0, 0, 0, 5);

    phase = "rst_pend";
    run_cyc(1, 0, 0, 5, 0, 0, 0, 5);
    run_cyc(1, 1, 6, 5, 1, 1, 0, 5);
    rst = 1'b1;
    idle_cyc(1, 0, 0, 0, 3);
    rst = 1'b0;
    idle_cyc(0, 0, 0, 0, 3);
    for (int i = 0; i < 6; i++) run_cyc(1, 0, 0, 3, i % 3, 0, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ratio_ctrl.md
DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the ratio and the period counter.
REQ-002 Parameter: RST_RATIO, default 3, divide ratio loaded at reset; legal range 2..2^CNT_W-1.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  run request; 1 = generate divided output, 0 = stop at the next period boundary.
REQ-006 Port: cfg_valid  input  1  new-ratio request.
REQ-007 Port: cfg_ratio  input  CNT_W  requested divide ratio N.
REQ-008 Port: cfg_ready  output  1  controller can accept a request this cycle.
REQ-009 Port: cfg_err  output  1  one-cycle pulse when an accepted request carries an illegal ratio.
REQ-010 Port: div_out  output  1  divided clock, period N clk cycles.
REQ-011 Port: period_tick  output  1  one-cycle pulse in the first cycle of each div_out period.
REQ-012 Port: active_ratio  output  CNT_W  ratio currently in effect.
REQ-013 Port: busy  output  1  a ratio change is pending.

Function
REQ-014 The block SHALL hold state IDLE, RUN or PEND, a period counter cnt (CNT_W bits), active_ratio and a pending-ratio register.
REQ-015 All outputs SHALL decode from registered state only, with no combinational path from any input to any output.
REQ-016 div_out SHALL be 1 when state is RUN or PEND and cnt < ceil(N/2); otherwise it SHALL be 0 (N=3 gives 1,1,0; N=4 gives 1,1,0,0; N=5 gives 1,1,1,0,0).
REQ-017 period_tick SHALL be 1 when state is RUN or PEND and cnt==0.
REQ-018 In RUN and PEND, cnt SHALL increment each cycle and wrap from N-1 to 0; the cycle with cnt==N-1 is the period boundary.
REQ-019 IDLE -> RUN SHALL occur on the edge where en is sampled 1, with cnt=0, so period_tick and div_out rise in the following cycle.
REQ-020 In IDLE, cnt SHALL be held at 0 and div_out SHALL be held at 0.
REQ-021 en sampled 0 in RUN or PEND SHALL take effect only at the period boundary: the state goes to IDLE and cnt to 0, so the final period is always complete.
REQ-022 If en returns to 1 before that boundary, no stop SHALL occur.
REQ-023 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-024 A handshake SHALL occur on a cycle where cfg_valid and cfg_ready are both 1.
REQ-025 On a handshake with cfg_ratio < 2, the request SHALL be dropped, cfg_err SHALL pulse for one cycle, and state, ratio and cnt SHALL be unchanged.
REQ-026 On a legal handshake in IDLE, active_ratio SHALL take cfg_ratio on the same edge.
REQ-027 On a legal handshake in RUN, cfg_ratio SHALL be stored as pending, the state SHALL go to PEND, and busy SHALL be 1.
REQ-028 A legal handshake in RUN on the boundary cycle itself SHALL still go to PEND, and the old ratio SHALL run one further full period.
REQ-029 At the boundary in PEND, active_ratio SHALL take the pending value, cnt SHALL wrap to 0, and the state SHALL return to RUN, or to IDLE if en is 0.
REQ-030 Ratio changes SHALL occur only at period boundaries, with no runt or glitch pulse on div_out.
REQ-031 busy SHALL equal (state==PEND).

Reset
REQ-032 When rst is sampled 1, the next state SHALL be IDLE regardless of state or other inputs, including mid-period and mid-PEND.
REQ-033 Reset values SHALL be: cnt=0, active_ratio=RST_RATIO, pending register=RST_RATIO, div_out=0, period_tick=0, cfg_ready=1, cfg_err=0, busy=0.
REQ-034 rst SHALL have priority over en and over any cfg handshake in the same cycle.

Verification
REQ-035 The bench SHALL cover: reset, then en=1 held for 12 cycles -> div_out 1,1,0 repeated 4 times, period_tick on cycles 1, 4, 7 and 10 after en is sampled.
REQ-036 The bench SHALL cover: running N=3, cfg_ratio=5 handshake at cnt==1 -> busy=1 and cfg_ready=0 until the boundary, then div_out 1,1,1,0,0 and active_ratio=5.
REQ-037 The bench SHALL cover: cfg_ratio=1 and cfg_ratio=0 handshakes in IDLE and in RUN -> cfg_err one-cycle pulse each, active_ratio unchanged, div_out pattern undisturbed.
REQ-038 The bench SHALL cover: N=4, en dropped at cnt==1 -> the period completes (1,1,0,0), then IDLE with div_out=0 and no further period_tick.
REQ-039 The bench SHALL cover: handshake with cfg_ratio=4 on the boundary cycle of N=3 -> one more 3-cycle period, then 4-cycle periods.
REQ-040 The bench SHALL cover: rst asserted mid-PEND with en=1 -> next cycle IDLE, active_ratio=3, busy=0, div_out=0, and the pending ratio discarded.
